mips_mc_control: RTL
====================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have these inputs:
- opcode input 6: instruction register bits [31:26].
- zero input 1: ALU zero flag.
- mem_ready input 1: memory access complete this cycle.
REQ-003 SHALL have these datapath-enable outputs:
- pc_write output 1
- pc_write_cond output 1
- iord output 1
- mem_read output 1
- mem_write output 1
- ir_write output 1
- mem_to_reg output 1
- reg_dst output 1
- reg_write output 1
- alu_src_a output 1
REQ-004 SHALL have alu_src_b output 2: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-005 SHALL have aluop output 2, feeding alu_control: 00 add, 01 subtract, 10 use funct field.
REQ-006 SHALL have pc_source output 2: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-007 SHALL have these status outputs:
- instr_done output 1: one-cycle pulse when an instruction retires.
- illegal_op output 1: one-cycle pulse on an unsupported opcode.
- state_o output 4: current state encoding.

Function
REQ-008 SHALL implement a Moore FSM with these states: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP.
REQ-009 SHALL go IDLE -> FETCH unconditionally one cycle after reset release.
REQ-010 SHALL behave as follows in FETCH:
- Assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00 and pc_source=00.
- Assert pc_write and ir_write only in the cycle where mem_ready=1, then go to DECODE.
- Otherwise hold in FETCH.
REQ-011 SHALL drive alu_src_a=0, alu_src_b=11 and aluop=00 in DECODE, then select the next state by opcode:
- 000000 -> EXECUTE
- 100011 (lw) or 101011 (sw) -> MEM_ADDR
- 001000 (addi) -> ADDI_EXEC
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- any other opcode -> pulse illegal_op, go to FETCH
REQ-012 SHALL drive alu_src_a=1, alu_src_b=10 and aluop=00 in MEM_ADDR, then go to MEM_READ for lw or MEM_WRITE for sw; opcode SHALL remain stable from DECODE onward.
REQ-013 SHALL drive mem_read=1 and iord=1 in MEM_READ, holding until mem_ready=1, then go to MEM_WB.
REQ-014 SHALL drive mem_write=1 and iord=1 in MEM_WRITE, holding until mem_ready=1, then pulse instr_done and go to FETCH.
REQ-015 SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0 in MEM_WB, then pulse instr_done and go to FETCH.
REQ-016 SHALL drive alu_src_a=1, alu_src_b=00 and aluop=10 in EXECUTE, then go to ALU_WB.
REQ-017 SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0 in ALU_WB, then go to FETCH with instr_done.
REQ-018 SHALL drive alu_src_a=1, alu_src_b=10 and aluop=00 in ADDI_EXEC; in ADDI_WB it SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH with instr_done.
REQ-019 SHALL drive alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1 and pc_source=01 in BRANCH; PC updates only when zero=1; the state SHALL then go to FETCH with instr_done.
REQ-020 SHALL drive pc_write=1 and pc_source=10 in JUMP, then go to FETCH with instr_done.
REQ-021 SHALL drive every output not listed for a state to 0.
REQ-022 SHALL never assert mem_read and mem_write in the same cycle.
REQ-023 SHALL give each instruction this latency with mem_ready tied high:
- lw: 5 cycles
- sw, R-type, addi: 4 cycles
- beq, j: 3 cycles
Each cycle of mem_ready low SHALL add exactly one cycle.

Reset
REQ-024 SHALL force state to IDLE immediately on rst_n low, including mid-instruction, with all outputs 0 and state_o=0.
REQ-025 SHALL hold pc_write, reg_write, mem_write and ir_write at 0 throughout reset and in IDLE.

Structure
REQ-026 SHALL place the state enum, opcode constants, and aluop/alu_src_b/pc_source encodings in shared package mips_ctrl_pkg.
REQ-027 SHALL be a single module with no sub-modules, with the state register separated from the next-state/output logic.

Verification
REQ-028 SHALL cover: reset release, mem_ready=1, opcode=000000 -> state sequence IDLE, FETCH, DECODE, EXECUTE (aluop=10), ALU_WB (reg_write=1, reg_dst=1), FETCH; instr_done pulses once.
REQ-029 SHALL cover: opcode=100011 with mem_ready low for 3 cycles in MEM_READ -> lw takes 8 cycles; mem_read=1 and iord=1 held throughout the stall.
REQ-030 SHALL cover: opcode=000100 -> BRANCH asserts aluop=01 and pc_write_cond=1 for both zero=0 and zero=1; pc_write stays 0.
REQ-031 SHALL cover: opcode=111111 -> illegal_op pulses once in DECODE; next state is FETCH; no write enables are asserted.
REQ-032 SHALL cover: rst_n dropped while in MEM_WRITE -> mem_write=0 in the same cycle and state_o=IDLE; after release, the FSM restarts at FETCH.
REQ-033 SHALL cover: FETCH with mem_ready=0 for 2 cycles -> pc_write and ir_write are 0 on those cycles and assert only on the mem_ready=1 cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// State enum, opcode constants and the datapath mux/ALU select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-unit <-> datapath/memory signal bundle.
// Memory handshake: an access is requested while mem_read or mem_write is high and
// completes in the cycle mem_ready is sampled high; the request is held stable until then.
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluop;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
           pc_source, instr_done, illegal_op, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
           pc_source, instr_done, illegal_op, state_o
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM: Moore state register plus combinational
// next-state/output decode; FETCH/MEM_* completion and DECODE illegal detection look at inputs.
module mips_mc_control
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mips_mc_control_if.master  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // PC and IR capture only when the instruction word is actually valid.
        if (bus.mem_ready) begin
          ctrl.pc_write = 1'b1;
          ctrl.ir_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SHL;
        ctrl.aluop     = ALUOP_ADD;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.aluop     = ALUOP_FUNCT;
        state_d        = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        // The datapath gates pc_write_cond with zero; the FSM retires the branch either way.
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.aluop         = ctrl.aluop;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.state_o       = state_q;

endmodule
